// File: rtl/adderv2_core.sv
// adderv2_core: two-cycle split-carry unsigned adder with accumulate mode, done pulse and op counter.
// Optional feature: define ADDERV2_SATURATE_EN to clamp the result to all-ones on carry-out.
module adderv2_core #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  start,
  input  logic                  accum_mode,
  input  logic                  clear_acc,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  ovf_sticky,
  output logic                  busy,
  output logic                  done,
  output logic                  collision,
  output logic [CNT_WIDTH-1:0]  op_count
);

  localparam int HALF = DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD_LO = 2'd1,
    ADD_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic [HALF-1:0]       sum_lo_r;
  logic                  c_lo_r;
  logic                  carry_r;
  logic                  ovf_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  coll_r;
  logic [CNT_WIDTH-1:0]  cnt_r;

  logic [HALF:0]         lo_sum_s;
  logic [HALF:0]         hi_sum_s;
  logic [DATA_WIDTH-1:0] a_sel_s;
  logic [DATA_WIDTH-1:0] hi_result_s;

  // Half-adders, operand-A selection and final result formatting.
  always_comb begin
    lo_sum_s    = {1'b0, a_r[HALF-1:0]} + {1'b0, b_r[HALF-1:0]};
    hi_sum_s    = {1'b0, a_r[DATA_WIDTH-1:HALF]} + {1'b0, b_r[DATA_WIDTH-1:HALF]}
                + {{HALF{1'b0}}, c_lo_r};
    a_sel_s     = op_a;
    hi_result_s = {hi_sum_s[HALF-1:0], sum_lo_r};
    // A simultaneous clear takes effect before the accumulator is sampled.
    if (accum_mode) begin
      if (clear_acc) begin
        a_sel_s = {DATA_WIDTH{1'b0}};
      end else begin
        a_sel_s = result_r;
      end
    end else begin
      a_sel_s = op_a;
    end
`ifdef ADDERV2_SATURATE_EN
    if (hi_sum_s[HALF]) begin
      hi_result_s = {DATA_WIDTH{1'b1}};
    end else begin
      hi_result_s = {hi_sum_s[HALF-1:0], sum_lo_r};
    end
`else
    hi_result_s = {hi_sum_s[HALF-1:0], sum_lo_r};
`endif
  end

  // Operation sequencer with all status and result registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r  <= IDLE;
      a_r      <= {DATA_WIDTH{1'b0}};
      b_r      <= {DATA_WIDTH{1'b0}};
      result_r <= {DATA_WIDTH{1'b0}};
      sum_lo_r <= {HALF{1'b0}};
      c_lo_r   <= 1'b0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      coll_r   <= 1'b0;
      cnt_r    <= {CNT_WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (clear_acc) begin
            result_r <= {DATA_WIDTH{1'b0}};
            carry_r  <= 1'b0;
            ovf_r    <= 1'b0;
          end
          if (start) begin
            a_r     <= a_sel_s;
            b_r     <= op_b;
            busy_r  <= 1'b1;
            state_r <= ADD_LO;
          end
        end
        ADD_LO: begin
          sum_lo_r <= lo_sum_s[HALF-1:0];
          c_lo_r   <= lo_sum_s[HALF];
          state_r  <= ADD_HI;
        end
        ADD_HI: begin
          result_r <= hi_result_s;
          carry_r  <= hi_sum_s[HALF];
          ovf_r    <= ovf_r | hi_sum_s[HALF];
          done_r   <= 1'b1;
          state_r  <= DONE;
        end
        DONE: begin
          cnt_r   <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
      // Requests landing on any non-IDLE state are dropped but remembered.
      if ((state_r != IDLE) && (start || clear_acc)) begin
        coll_r <= 1'b1;
      end
    end
  end

  assign result     = result_r;
  assign carry      = carry_r;
  assign ovf_sticky = ovf_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign collision  = coll_r;
  assign op_count   = cnt_r;

endmodule

// File: tb/tb_adderv2_core.sv
// Directed self-checking bench for adderv2_core; a second instance with CNT_WIDTH=2 shows counter wrap.
module tb_adderv2_core;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        start;
  logic        accum_mode;
  logic        clear_acc;

  logic [31:0] result;
  logic        carry;
  logic        ovf_sticky;
  logic        busy;
  logic        done;
  logic        collision;
  logic [15:0] op_count;

  logic [31:0] result2;
  logic        carry2;
  logic        ovf_sticky2;
  logic        busy2;
  logic        done2;
  logic        collision2;
  logic [1:0]  op_count2;

  int tests_run;
  int tests_failed;

  adderv2_core #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .op_a(op_a), .op_b(op_b), .start(start),
    .accum_mode(accum_mode), .clear_acc(clear_acc), .result(result), .carry(carry),
    .ovf_sticky(ovf_sticky), .busy(busy), .done(done), .collision(collision),
    .op_count(op_count)
  );

  adderv2_core #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut2 (
    .ACLK(ACLK), .ARESET(ARESET), .op_a(op_a), .op_b(op_b), .start(start),
    .accum_mode(accum_mode), .clear_acc(clear_acc), .result(result2), .carry(carry2),
    .ovf_sticky(ovf_sticky2), .busy(busy2), .done(done2), .collision(collision2),
    .op_count(op_count2)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation started now; op_a/op_b are scrambled after the start cycle.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic acc, input logic [31:0] exp_res, input logic exp_c);
    op_a = a; op_b = b; accum_mode = acc; start = 1'b1;
    step();
    start = 1'b0;
    op_a = 32'hDEAD_BEEF; op_b = 32'h5A5A_5A5A;
    check({tag, " busy k+1"}, {63'd0, busy}, 64'd1);
    check({tag, " done k+1"}, {63'd0, done}, 64'd0);
    step();
    step();
    check({tag, " done k+3"}, {63'd0, done}, 64'd1);
    check({tag, " busy k+3"}, {63'd0, busy}, 64'd1);
    check({tag, " result"}, {32'd0, result}, {32'd0, exp_res});
    check({tag, " carry"}, {63'd0, carry}, {63'd0, exp_c});
    step();
    check({tag, " done k+4"}, {63'd0, done}, 64'd0);
    check({tag, " busy k+4"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    ARESET = 1'b1; op_a = 32'd0; op_b = 32'd0;
    start = 1'b0; accum_mode = 1'b0; clear_acc = 1'b0;
    step(); step();
    ARESET = 1'b0;
    step();
    check("rst result", {32'd0, result}, 64'd0);
    check("rst carry", {63'd0, carry}, 64'd0);
    check("rst ovf", {63'd0, ovf_sticky}, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst collision", {63'd0, collision}, 64'd0);
    check("rst op_count", {48'd0, op_count}, 64'd0);

    do_op("1+2", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0);
    check("1+2 op_count", {48'd0, op_count}, 64'd1);

    do_op("half carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0);
    check("half carry op_count", {48'd0, op_count}, 64'd2);

`ifdef ADDERV2_SATURATE_EN
    do_op("wrap", 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 1'b1);
`else
    do_op("wrap", 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 1'b1);
`endif
    check("wrap ovf", {63'd0, ovf_sticky}, 64'd1);
    check("wrap op_count2", {62'd0, op_count2}, 64'd3);

    clear_acc = 1'b1;
    step();
    clear_acc = 1'b0;
    check("clear result", {32'd0, result}, 64'd0);
    check("clear carry", {63'd0, carry}, 64'd0);
    check("clear ovf", {63'd0, ovf_sticky}, 64'd0);
    do_op("acc1", 32'h1234_5678, 32'd1, 1'b1, 32'h0000_0001, 1'b0);
    check("acc1 op_count2 wrap", {62'd0, op_count2}, 64'd0);
    do_op("acc2", 32'h1234_5678, 32'd2, 1'b1, 32'h0000_0003, 1'b0);
    do_op("acc3", 32'h1234_5678, 32'd3, 1'b1, 32'h0000_0006, 1'b0);
    do_op("acc4", 32'h1234_5678, 32'd4, 1'b1, 32'h0000_000A, 1'b0);
    check("acc op_count", {48'd0, op_count}, 64'd7);
    check("acc collision", {63'd0, collision}, 64'd0);

    // Collision: extra start in ADD_LO and clear in ADD_HI are both dropped.
    op_a = 32'h0000_0010; op_b = 32'h0000_0020; accum_mode = 1'b0; start = 1'b1;
    step();
    step();
    start = 1'b0; clear_acc = 1'b1;
    step();
    clear_acc = 1'b0;
    check("coll done", {63'd0, done}, 64'd1);
    check("coll result", {32'd0, result}, 64'h30);
    check("coll flag", {63'd0, collision}, 64'd1);
    step();
    check("coll busy k+4", {63'd0, busy}, 64'd0);
    check("coll result held", {32'd0, result}, 64'h30);
    check("coll op_count", {48'd0, op_count}, 64'd8);

    clear_acc = 1'b1;
    op_a = 32'h0000_0777; op_b = 32'd5; accum_mode = 1'b1; start = 1'b1;
    step();
    clear_acc = 1'b0; start = 1'b0;
    check("start+clear busy", {63'd0, busy}, 64'd1);
    step(); step();
    check("start+clear done", {63'd0, done}, 64'd1);
    check("start+clear result", {32'd0, result}, 64'h5);
    step();
    check("start+clear op_count", {48'd0, op_count}, 64'd9);
    check("collision sticky", {63'd0, collision}, 64'd1);

    // Reset in cycle k+2 aborts the operation silently.
    op_a = 32'd1; op_b = 32'd1; accum_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    check("midrst done", {63'd0, done}, 64'd0);
    check("midrst busy", {63'd0, busy}, 64'd0);
    check("midrst result", {32'd0, result}, 64'd0);
    check("midrst op_count", {48'd0, op_count}, 64'd0);
    check("midrst collision", {63'd0, collision}, 64'd0);
    step();
    check("midrst no late done", {63'd0, done}, 64'd0);
    do_op("post rst", 32'd7, 32'd8, 1'b0, 32'h0000_000F, 1'b0);
    check("post rst op_count", {48'd0, op_count}, 64'd1);
    check("post rst op_count2", {62'd0, op_count2}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
